regfile_write_scheduler: RTL and testbench

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_write_scheduler_if.sv | 30 +++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/regfile_write_scheduler.sv | 85 ++++++++
 tb/tb_regfile_write_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package regfile_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 5;
  localparam int NUM_REGS  = 2 ** DEF_DEPTH;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Requester handshakes plus the register-file write port of the scheduler.
interface regfile_write_scheduler_if #(
  parameter int WIDTH = regfile_pkg::DEF_WIDTH,
  parameter int DEPTH = regfile_pkg::DEF_DEPTH
);

  logic             a_valid;
  logic             a_ready;
  logic [DEPTH-1:0] a_rd;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [DEPTH-1:0] b_rd;
  logic [WIDTH-1:0] b_data;
  logic             regWrite;
  logic [DEPTH-1:0] writeReg;
  logic [WIDTH-1:0] dataWrite;
  logic             init_done;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, regWrite, writeReg, dataWrite, init_done
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, regWrite, writeReg, dataWrite, init_done
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is consumed.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Remembers who won last; resetting to REQ_B gives A first priority.
  req_id_t last_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_reg == REQ_A) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= REQ_B;
    end else if (advance && (grant != 2'b00)) begin
      last_reg <= grant[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Clears the register file after reset, then merges two writeback streams
// onto the single registered write port with round-robin arbitration.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  regfile_write_scheduler_if.slave  bus
);

  state_t           state_reg;
  logic [DEPTH-1:0] sweep_cnt_reg;
  logic             reg_write_reg;
  logic [DEPTH-1:0] write_addr_reg;
  logic [WIDTH-1:0] write_data_reg;
  logic             init_done_reg;

  logic             run;
  logic [1:0]       grant;
  logic             xfer;
  logic [DEPTH-1:0] sel_rd;
  logic [WIDTH-1:0] sel_data;

  // Requests are masked outside RUN, so ready is also low during reset and the sweep.
  assign run = (state_reg == RUN);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.b_valid, bus.a_valid} & {2{run}}),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer     = |grant;
  assign sel_rd   = grant[1] ? bus.b_rd   : bus.a_rd;
  assign sel_data = grant[1] ? bus.b_data : bus.a_data;

  assign bus.a_ready   = grant[0];
  assign bus.b_ready   = grant[1];
  assign bus.regWrite  = reg_write_reg;
  assign bus.writeReg  = write_addr_reg;
  assign bus.dataWrite = write_data_reg;
  assign bus.init_done = init_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= INIT;
      sweep_cnt_reg  <= DEPTH'(1);
      reg_write_reg  <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      init_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          // The counter wraps to zero once the top address has been written.
          if (sweep_cnt_reg == '0) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
            reg_write_reg <= 1'b0;
          end else begin
            reg_write_reg  <= 1'b1;
            write_addr_reg <= sweep_cnt_reg;
            write_data_reg <= '0;
            sweep_cnt_reg  <= sweep_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          // Writes to r0 finish the handshake but never reach the port.
          reg_write_reg <= xfer && (sel_rd != '0);
          if (xfer && (sel_rd != '0)) begin
            write_addr_reg <= sel_rd;
            write_data_reg <= sel_data;
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomised and directed checks of the write scheduler against a behavioural model.
module tb_regfile_write_scheduler;

  localparam int W  = 64;
  localparam int D  = 5;
  localparam int NR = 32;

  logic clk;
  logic rst_n;

  regfile_write_scheduler_if #(.WIDTH(W), .DEPTH(D)) bus();

  regfile_write_scheduler #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: edges since reset release, grant history, one pending port write.
  int          n;
  logic        last_was_a;
  logic        pend_v;
  logic [4:0]  pend_rd;
  logic [63:0] pend_data;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [63:0] exp_wd;

  initial begin : model_edge
    n = 0; last_was_a = 1'b0; pend_v = 1'b0; pend_rd = '0; pend_data = '0;
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; last_was_a = 1'b0; pend_v = 1'b0;
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      end else begin
        if (n < 1000) n++;
        if (n < NR) begin
          exp_we = 1'b1; exp_wa = 5'(n); exp_wd = '0;
        end else begin
          exp_we = pend_v && (pend_rd != 0);
          if (exp_we) begin
            exp_wa = pend_rd; exp_wd = pend_data;
          end
          pend_v = 1'b0;
        end
      end
    end
  end

  initial begin : compare
    logic ea, eb, run;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_b_ready", bus.b_ready, 0);
        check("rst_regWrite", bus.regWrite, 0);
        check("rst_writeReg", bus.writeReg, 0);
        check("rst_dataWrite", bus.dataWrite, 0);
        check("rst_init_done", bus.init_done, 0);
      end else begin
        run = (n >= NR);
        ea = 1'b0; eb = 1'b0;
        if (run) begin
          if (bus.a_valid && bus.b_valid) begin
            ea = !last_was_a; eb = last_was_a;
          end else begin
            ea = bus.a_valid; eb = bus.b_valid;
          end
        end
        check("a_ready", bus.a_ready, ea);
        check("b_ready", bus.b_ready, eb);
        check("init_done", bus.init_done, run);
        check("regWrite", bus.regWrite, exp_we);
        check("writeReg", bus.writeReg, exp_wa);
        check("dataWrite", bus.dataWrite, exp_wd);
        if (ea || eb) begin
          pend_v     = 1'b1;
          pend_rd    = ea ? bus.a_rd : bus.b_rd;
          pend_data  = ea ? bus.a_data : bus.b_data;
          last_was_a = ea;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int k;
    int port_exp [4];
    logic acc_a, acc_b;
    port_exp = '{1, 3, 2, 4};

    // A held valid from reset: no ready during the sweep.
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 64'hABCD;
    bus.b_valid = 1'b0; bus.b_rd = '0;   bus.b_data = '0;
    repeat (3) step();
    check("lit_reset_regWrite", bus.regWrite, 0);
    check("lit_reset_a_ready", bus.a_ready, 0);
    rst_n = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.a_ready) break;
    end
    check("lit_first_ready_cycle", k, 32);
    check("lit_first_ready_init_done", bus.init_done, 1);
    step(); bus.a_valid = 1'b0;
    @(negedge clk);
    check("lit_held_a_regWrite", bus.regWrite, 1);
    check("lit_held_a_writeReg", bus.writeReg, 7);
    check("lit_held_a_data", bus.dataWrite, 64'hABCD);

    // Single A write.
    step(); bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 64'h1234;
    @(negedge clk);
    check("lit_a_only_ready", bus.a_ready, 1);
    check("lit_a_only_b_ready", bus.b_ready, 0);
    step(); bus.a_valid = 1'b0;
    @(negedge clk);
    check("lit_a_only_regWrite", bus.regWrite, 1);
    check("lit_a_only_writeReg", bus.writeReg, 5);
    check("lit_a_only_data", bus.dataWrite, 64'h1234);

    // A B-only write hands priority back to A before the contention run.
    step(); bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 64'h99;
    @(negedge clk);
    check("lit_b_only_ready", bus.b_ready, 1);
    step();
    bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 64'h11;
    bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 64'h33;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("lit_rr_regWrite", bus.regWrite, 1);
        check("lit_rr_writeReg", bus.writeReg, port_exp[i-1]);
      end
      if (i < 4) check("lit_rr_a_grant", bus.a_ready, (i % 2 == 0));
      if (i < 4) begin
        step();
        case (i)
          0: begin bus.a_rd = 5'd2; bus.a_data = 64'h22; end
          1: begin bus.b_rd = 5'd4; bus.b_data = 64'h44; end
          2: bus.a_valid = 1'b0;
          default: bus.b_valid = 1'b0;
        endcase
      end
    end

    // Write to r0 is accepted but suppressed.
    step(); bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 64'hFF;
    @(negedge clk);
    check("lit_r0_ready", bus.a_ready, 1);
    step(); bus.a_valid = 1'b0;
    @(negedge clk);
    check("lit_r0_regWrite", bus.regWrite, 0);

    // Random traffic with one reset dropped in mid-run.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      if (i == 700) begin
        #1 rst_n = 1'b0;
      end
      step();
      if (i == 703) rst_n = 1'b1;
      if (!bus.a_valid || acc_a) begin
        bus.a_valid = ($urandom_range(0, 99) < 60);
        bus.a_rd    = 5'($urandom_range(0, 7));
        bus.a_data  = {$urandom, $urandom};
      end
      if (!bus.b_valid || acc_b) begin
        bus.b_valid = ($urandom_range(0, 99) < 60);
        bus.b_rd    = 5'($urandom_range(0, 7));
        bus.b_data  = {$urandom, $urandom};
      end
    end

    // Reset in the middle of the sweep, then a clean sweep with idle requesters.
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    check("lit_sweep_at_10", bus.writeReg, 10);
    #1 rst_n = 1'b0;
    #1;
    check("lit_async_regWrite", bus.regWrite, 0);
    check("lit_async_writeReg", bus.writeReg, 0);
    check("lit_async_init_done", bus.init_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("lit_restart_idle", bus.regWrite, 0);
    @(negedge clk);
    check("lit_restart_first_we", bus.regWrite, 1);
    check("lit_restart_first_addr", bus.writeReg, 1);
    repeat (29) @(negedge clk);
    @(negedge clk);
    check("lit_sweep_last_addr", bus.writeReg, 31);
    check("lit_sweep_last_data", bus.dataWrite, 0);
    check("lit_sweep_last_init_done", bus.init_done, 0);
    @(negedge clk);
    check("lit_run_init_done", bus.init_done, 1);
    check("lit_run_regWrite", bus.regWrite, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
